// File: rtl/fetch_pkg.sv
// fetch_pkg: CPU-wide fetch definitions shared by the fetch stage and its FIFO.
//   NOP                  canonical no-op (addi x0,x0,0) used for faulted/empty entries
//   EXC_INSN_*           fetch exception cause codes
//   entry_w()            packed fetch-entry width: {pc, insn, exc_en, exc_code, exc_val}
//   fetch_state_e        RUN/HALT state of the fetch FSM
package fetch_pkg;
  localparam logic [31:0] NOP                 = 32'h00000013;
  localparam logic [3:0]  EXC_INSN_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSN_ACCESS     = 4'd1;
  localparam int          INSN_W              = 32;
  localparam int          CODE_W              = 4;

  function automatic int entry_w(input int xlen);
    return xlen + INSN_W + 1 + CODE_W + xlen;
  endfunction

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO holding packed fetch entries.
//   clk, rst_n   clock / async active-low reset
//   push, wdata  enqueue (accepted when not full, or full with a same-cycle pop)
//   pop          dequeue head (ignored when empty)
//   flush        empties the FIFO; overrides push and pop
//   head, count  registered head entry and occupancy (0..2)
module fetch_fifo #(
  parameter int W = 165
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   count_q, count_d, occ;
  logic         do_pop, do_push;

  // slot0 is always the head; a pop shifts slot1 forward, so a push lands
  // in whichever slot is first free after the pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop & (count_q != 2'd0);
    do_push = push & ((count_q != 2'd2) | do_pop);
    occ     = count_q - {1'b0, do_pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) slot0_d = slot1_q;
      if (do_push) begin
        if (occ == 2'd0) slot0_d = wdata;
        else             slot1_d = wdata;
      end
      count_d = occ + {1'b0, do_push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Owns the fetch PC, samples the combinational
// instruction memory into a 2-entry FIFO and hands entries to decode.
//   pc_addr                       fetch address (PC register)
//   imem_instruction/exc_*        memory response for pc_addr
//   redirect_valid/redirect_pc    flush + new PC (highest priority)
//   id_valid/id_ready             decode handshake on the FIFO head
//   id_pc/instruction/exc_*       head entry, forced to NOP/zeros when empty
//   fetch_halted                  fetch frozen after an exception entry
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     imem_instruction,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instruction,
  output logic            id_exc_en,
  output logic [3:0]      id_exc_code,
  output logic [XLEN-1:0] id_exc_val,
  output logic            fetch_halted
);
  localparam int EW = entry_w(XLEN);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            deq, fetch_en, misaligned;
  logic [EW-1:0]   wdata, head;
  logic [1:0]      count;
  logic [XLEN-1:0] h_pc, h_val;
  logic [31:0]     h_insn;
  logic            h_exc;
  logic [3:0]      h_code;

  assign pc_addr    = pc_q;
  assign id_valid   = (count != 2'd0);
  assign deq        = id_valid & id_ready;
  assign misaligned = (pc_q[1:0] != 2'b00);
  // id_ready feeds fetch_en directly so a full FIFO can still refill on a pop.
  assign fetch_en   = (state_q == ST_RUN) & ((count != 2'd2) | deq) & ~redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wdata   = {pc_q, imem_instruction, 1'b0, 4'd0, {XLEN{1'b0}}};
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else if (fetch_en) begin
      // Faulting fetches hold the PC and freeze in HALT, so the memory fault
      // flag is captured exactly once for a given PC.
      if (misaligned) begin
        wdata   = {pc_q, NOP, 1'b1, EXC_INSN_MISALIGNED, pc_q};
        state_d = ST_HALT;
      end else if (imem_exc_en) begin
        wdata   = {pc_q, NOP, 1'b1, imem_exc_code, imem_exc_val};
        state_d = ST_HALT;
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_en),
    .pop   (deq),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign {h_pc, h_insn, h_exc, h_code, h_val} = head;

  assign id_pc          = id_valid ? h_pc   : '0;
  assign id_instruction = id_valid ? h_insn : NOP;
  assign id_exc_en      = id_valid & h_exc;
  assign id_exc_code    = id_valid ? h_code : 4'd0;
  assign id_exc_val     = id_valid ? h_val  : '0;
  assign fetch_halted   = (state_q == ST_HALT);
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory; owns the architectural fetch PC and drives the memory's PC address input.
- Samples the combinational instruction memory response (instruction plus access-fault signals) into a 2-entry buffer.
- Presents fetched entries to decode through a valid/ready handshake.
- Handles redirects from branch/trap logic and freezes fetch after any fetch exception until redirected.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- XLEN, 64, PC and exception-value width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_addr  out  XLEN  fetch address to instruction memory; equals the PC register.
- imem_instruction  in  32  instruction word returned by memory, combinational from pc_addr.
- imem_exc_en  in  1  memory access-fault flag.
- imem_exc_code  in  4  memory exception cause.
- imem_exc_val  in  XLEN  memory fault value (bad PC).
- redirect_valid  in  1  PC redirect from branch/trap unit.
- redirect_pc  in  XLEN  redirect target.
- id_ready  in  1  decode accepts the head entry.
- id_valid  out  1  head entry valid.
- id_pc  out  XLEN  PC of the head entry.
- id_instruction  out  32  instruction of the head entry.
- id_exc_en  out  1  head entry carries a fetch exception.
- id_exc_code  out  4  cause: 0 = misaligned, 1 = access fault.
- id_exc_val  out  XLEN  faulting PC.
- fetch_halted  out  1  fetch frozen after an exception.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC; FIFO count = 0; state RUN.
  - id_valid = 0, id_pc = 0, id_instruction = 32'h00000013, id_exc_en = 0, id_exc_code = 0, id_exc_val = 0, fetch_halted = 0.
- States:
  - RUN: fetching.
  - HALT: exception entry enqueued; no fetch.
- deq = id_valid & id_ready.
- fetch_en = (state == RUN) & (count < 2 | deq) & ~redirect_valid.
- On fetch_en, at the clock edge:
  - Misaligned (pc[1:0] != 0), which takes priority over the memory fault: enqueue {pc, NOP, exc_en=1, code=0, val=pc}; go to HALT; pc holds.
  - Else if imem_exc_en: enqueue {pc, NOP, exc_en=1, code=imem_exc_code, val=imem_exc_val}; go to HALT; pc holds.
  - Else: enqueue {pc, imem_instruction, no exception}; pc <= pc + 4 (mod 2^64, wraps silently).
- The memory's exc_en is sampled only on the first fetch at a faulting PC. HALT guarantees this single capture, so the memory's toggling fault flag is never re-read.
- Redirect (highest priority):
  - FIFO flushed (count = 0), pc <= redirect_pc, state -> RUN.
  - No enqueue or dequeue takes effect that cycle.
  - An entry handshaken in that same cycle is discarded; decode must treat it as squashed.
- HALT: pc and state are held; the FIFO keeps draining via deq. Only a redirect or reset leaves HALT.
- Latency: a PC presented on pc_addr in cycle n appears on the id_* outputs in cycle n+1 (registered FIFO head).
- Throughput: 1 instruction/cycle with id_ready held high.
- Full FIFO: enqueue is allowed in the same cycle as a dequeue. id_ready therefore reaches fetch_en combinationally; this path is permitted.
- Empty FIFO: id_valid = 0; id_* data outputs are forced to the reset values (NOP, zeros).
- FIFO ordering is strict; no entry is dropped except by a redirect flush.
- fetch_halted = (state == HALT).

Decomposition:
- Shared header (cpu-wide defines): NOP constant 32'h00000013; fetch exception codes EXC_INSN_MISALIGNED = 0, EXC_INSN_ACCESS = 1; fetch-entry field widths/packing (XLEN + 32 + 1 + 4 + XLEN bits).
- One sub-module: fetch_fifo.
  - 2-entry synchronous FIFO with push/pop/flush and count.
  - Same-cycle push+pop legal when full.
  - flush overrides push/pop.
  - Async active-low reset.
- fetch_stage holds the PC register, the RUN/HALT FSM and the exception/redirect priority logic.

Test Plan:
- Reset then release with id_ready=1, memory holding sequential words -> pc_addr 0,4,8,...; id_pc 0,4,8 on consecutive cycles starting 1 cycle after release; id_exc_en=0.
- id_ready=0 for 4 cycles from a streaming state -> count reaches 2, pc_addr stalls at the third PC; after id_ready=1 the entries drain in order with no gap or loss.
- FIFO full, redirect_valid=1 with redirect_pc=0x100 -> next cycle id_valid=0, pc_addr=0x100; following cycle id_pc=0x100.
- Fetch reaches 0x2000 (index 2048, out of range) -> exactly one entry with id_exc_en=1, code 1, val 0x2000, instruction 0x13; fetch_halted=1, pc_addr held at 0x2000 indefinitely; redirect to 0x40 -> fetch_halted=0, fetch resumes at 0x40.
- Redirect to 0x102 -> entry with code 0, val 0x102, no memory-fault code; HALT entered.
- rst_n asserted asynchronously mid-stream with a full FIFO -> all outputs reach reset values immediately without a clock; after release pc_addr=RESET_PC.
